// File: rtl/btb_predictor_2bit_pkg.sv
// btb_predictor_2bit_pkg: shared constants for the BTB / direction predictor.
//   WORD_SIZE       default PC/target width
//   state_e         sweep FSM encodings (ST_INIT, ST_RUN)
//   cnt_wnt/cnt_wt  weakly-not-taken / weakly-taken counter values for a
//                   given counter width
package btb_predictor_2bit_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Weakly not taken: MSB clear, all lower bits set.
    function automatic int unsigned cnt_wnt(input int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 32'd1)) - 32'd1;
    endfunction

    // Weakly taken: MSB set, all lower bits clear.
    function automatic int unsigned cnt_wt(input int unsigned cnt_bits);
        return 32'd1 << (cnt_bits - 32'd1);
    endfunction

endpackage

// File: rtl/btb_predictor_2bit_sat_counter.sv
// sat_counter: combinational saturating up/down counter step.
//   cnt_in   current counter value
//   inc      1 = count up (capped at all-ones), 0 = count down (floored at 0)
//   cnt_out  next counter value
module sat_counter #(
    parameter int unsigned CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] cnt_in,
    input  logic                inc,
    output logic [CNT_BITS-1:0] cnt_out
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    always_comb begin
        cnt_out = cnt_in;
        if (inc) begin
            if (cnt_in != CNT_MAX) cnt_out = cnt_in + CNT_BITS'(1);
        end else begin
            if (cnt_in != '0) cnt_out = cnt_in - CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/btb_predictor_2bit.sv
// btb_predictor_2bit: direct-mapped branch target buffer with saturating
// counter direction prediction, for the IF stage.
//   clk, reset_n          clock, synchronous active-low reset
//   PC -> next_PC         combinational prediction (target on predicted-taken
//                         hit, else PC+1), pred_taken flags the redirect
//   init_done             table sweep finished, predictions enabled
//   upd_valid/upd_PC/upd_taken/upd_target
//                         resolve-stage training port, applied on posedge
// Optional build macro BTB_GSHARE_EN: counters move to a gshare PHT indexed
// by PC index XOR a global history register trained from upd_taken.
module btb_predictor_2bit
#(
    parameter int unsigned WORD_SIZE  = btb_predictor_2bit_pkg::WORD_SIZE,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned CNT_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] PC,
    output logic [WORD_SIZE-1:0] next_PC,
    output logic                 pred_taken,
    output logic                 init_done,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_PC,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target
);
    import btb_predictor_2bit_pkg::*;

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0] WNT = CNT_BITS'(cnt_wnt(CNT_BITS));
    localparam logic [CNT_BITS-1:0] WT  = CNT_BITS'(cnt_wt(CNT_BITS));

    if (INDEX_BITS + TAG_BITS > WORD_SIZE) begin : g_bad_params
        $error("INDEX_BITS + TAG_BITS must not exceed WORD_SIZE");
    end

    // Sweep FSM: clears the table one entry per cycle after reset.
    state_e                state_q;
    logic [INDEX_BITS-1:0] ptr_q;
    logic                  init_done_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            ptr_q <= ptr_q + INDEX_BITS'(1);
            if (ptr_q == '1) begin
                state_q     <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end
    end

    assign init_done = init_done_q;

    // BTB storage.
    logic                 valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];

    logic [INDEX_BITS-1:0] pc_idx, upd_idx;
    logic [TAG_BITS-1:0]   pc_tag, upd_tag;
    logic                  pc_hit, upd_hit;
    logic                  run_upd;

    assign pc_idx  = PC[INDEX_BITS-1:0];
    assign pc_tag  = PC[INDEX_BITS +: TAG_BITS];
    assign upd_idx = upd_PC[INDEX_BITS-1:0];
    assign upd_tag = upd_PC[INDEX_BITS +: TAG_BITS];
    assign pc_hit  = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign run_upd = reset_n && (state_q == ST_RUN) && upd_valid;

    logic [CNT_BITS-1:0] pred_cnt;
    logic [CNT_BITS-1:0] upd_cnt_cur;
    logic [CNT_BITS-1:0] upd_cnt_nxt;

`ifdef BTB_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;
    logic [CNT_BITS-1:0]   pht_q [ENTRIES];
    logic [INDEX_BITS-1:0] pht_upd_idx;

    // History shifts on every resolved branch; the PHT update uses the
    // pre-shift value so training matches the history seen at prediction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else if (run_upd) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
        end
    end

    assign pht_upd_idx = upd_idx ^ ghr_q;
    assign pred_cnt    = pht_q[pc_idx ^ ghr_q];
    assign upd_cnt_cur = pht_q[pht_upd_idx];
`else
    logic [CNT_BITS-1:0] cnt_q [ENTRIES];

    assign pred_cnt    = cnt_q[pc_idx];
    assign upd_cnt_cur = cnt_q[upd_idx];
`endif

    sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_upd_cnt (
        .cnt_in  (upd_cnt_cur),
        .inc     (upd_taken),
        .cnt_out (upd_cnt_nxt)
    );

    // Table writes: sweep clears in INIT, resolve port trains in RUN.
    always_ff @(posedge clk) begin
        if (reset_n && (state_q == ST_INIT)) begin
            valid_q[ptr_q] <= 1'b0;
`ifdef BTB_GSHARE_EN
            pht_q[ptr_q]   <= WNT;
`else
            cnt_q[ptr_q]   <= WNT;
`endif
        end else if (run_upd) begin
            if (upd_hit) begin
                if (upd_taken) target_q[upd_idx] <= upd_target;
`ifndef BTB_GSHARE_EN
                cnt_q[upd_idx] <= upd_cnt_nxt;
`endif
            end else if (upd_taken) begin
                // Allocation evicts whatever occupied this index.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
`ifndef BTB_GSHARE_EN
                cnt_q[upd_idx]    <= WT;
`endif
            end
`ifdef BTB_GSHARE_EN
            pht_q[pht_upd_idx] <= upd_cnt_nxt;
`endif
        end
    end

    // Zero-latency prediction from pre-update table contents.
    assign pred_taken = (state_q == ST_RUN) && pc_hit && pred_cnt[CNT_BITS-1];
    assign next_PC    = pred_taken ? target_q[pc_idx] : PC + WORD_SIZE'(1);

endmodule

// File: tb/tb_btb_predictor_2bit.sv
// tb_btb_predictor_2bit: directed self-checking bench for btb_predictor_2bit.
module tb_btb_predictor_2bit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] PC = 16'h0010;
    logic [15:0] next_PC;
    logic        pred_taken;
    logic        init_done;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_PC = 16'h0000;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    btb_predictor_2bit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PC         (PC),
        .next_PC    (next_PC),
        .pred_taken (pred_taken),
        .init_done  (init_done),
        .upd_valid  (upd_valid),
        .upd_PC     (upd_PC),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    always #5 clk = ~clk;

    // Counter training sequence on PC 0x0120 starting from cnt=10.
    // cnt after each: 01 00 01 10 11 11 10 01
    logic        seq_taken [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] seq_tgt   [8] = '{16'h0200, 16'h0200, 16'h0200, 16'h0200,
                                   16'h0200, 16'h0240, 16'h0240, 16'h0240};
    logic [15:0] seq_np    [8] = '{16'h0121, 16'h0121, 16'h0121, 16'h0200,
                                   16'h0200, 16'h0240, 16'h0240, 16'h0121};

    // One-cycle update pulse; returns #1 after the capturing edge.
    task automatic do_upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt);
        upd_PC = pc; upd_taken = t; upd_target = tgt; upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        PC = 16'h0010;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (init_done !== 1'b0 || pred_taken !== 1'b0 || next_PC !== 16'h0011) begin
            n_fail++;
            $display("FAIL reset_values: got done=%b pred=%b np=%h expected 0 0 0011",
                     init_done, pred_taken, next_PC);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (i < 256) begin
                if (init_done !== 1'b0 || next_PC !== 16'h0011 || pred_taken !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_busy cyc %0d: got done=%b np=%h expected 0 0011",
                             i, init_done, next_PC);
                end
            end else if (init_done !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_done cyc %0d: got %b expected 1", i, init_done);
            end
        end
    endtask

    task automatic test_reset_restart();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b expected 0", init_done);
        end
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk); #1;
            if (i == 255) begin
                n_checks++;
                if (init_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart_early: got done=%b expected 0", init_done);
                end
            end
            if (i == 256) begin
                n_checks++;
                if (init_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart_done: got done=%b expected 1", init_done);
                end
            end
            // Update during INIT (entry 5 already swept) must be dropped.
            if (i == 199) begin
                upd_PC = 16'h0305; upd_taken = 1'b1; upd_target = 16'h0500; upd_valid = 1'b1;
            end
            if (i == 200) upd_valid = 1'b0;
        end
    endtask

    task automatic test_init_ignore_and_wrap();
        PC = 16'h0305; #1;
        n_checks++;
        if (pred_taken !== 1'b0 || next_PC !== 16'h0306) begin
            n_fail++;
            $display("FAIL init_upd_ignored: got pred=%b np=%h expected 0 0306", pred_taken, next_PC);
        end
        PC = 16'hFFFF; #1;
        n_checks++;
        if (next_PC !== 16'h0000 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_wrap: got pred=%b np=%h expected 0 0000", pred_taken, next_PC);
        end
    endtask

`ifndef BTB_GSHARE_EN
    task automatic test_alloc_predict();
        PC = 16'h0120;
        upd_PC = 16'h0120; upd_taken = 1'b1; upd_target = 16'h0200; upd_valid = 1'b1;
        #1;
        n_checks++;
        if (next_PC !== 16'h0121 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_pre: got pred=%b np=%h expected 0 0121", pred_taken, next_PC);
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        n_checks++;
        if (next_PC !== 16'h0200 || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_hit: got pred=%b np=%h expected 1 0200", pred_taken, next_PC);
        end
        PC = 16'h0220; #1;
        n_checks++;
        if (next_PC !== 16'h0221 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL tag_miss: got pred=%b np=%h expected 0 0221", pred_taken, next_PC);
        end
    endtask

    task automatic test_counter();
        PC = 16'h0120;
        for (int k = 0; k < 8; k++) begin
            do_upd(16'h0120, seq_taken[k], seq_tgt[k]);
            n_checks++;
            if (next_PC !== seq_np[k]) begin
                n_fail++;
                $display("FAIL counter step %0d: got np=%h expected %h", k, next_PC, seq_np[k]);
            end
        end
    endtask

    task automatic test_same_index();
        PC = 16'h0145;
        upd_PC = 16'h0145; upd_taken = 1'b1; upd_target = 16'h0777; upd_valid = 1'b1;
        #1;
        n_checks++;
        if (next_PC !== 16'h0146) begin
            n_fail++;
            $display("FAIL same_idx_old: got np=%h expected 0146", next_PC);
        end
        @(posedge clk); #1;
        // Back-to-back: evicting update on same index, different tag.
        upd_PC = 16'h0245; upd_taken = 1'b1; upd_target = 16'h0888; upd_valid = 1'b1;
        #1;
        n_checks++;
        if (next_PC !== 16'h0777) begin
            n_fail++;
            $display("FAIL same_idx_new: got np=%h expected 0777", next_PC);
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if (next_PC !== 16'h0146) begin
            n_fail++;
            $display("FAIL evicted: got np=%h expected 0146", next_PC);
        end
        PC = 16'h0245; #1;
        n_checks++;
        if (next_PC !== 16'h0888 || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL replaced: got pred=%b np=%h expected 1 0888", pred_taken, next_PC);
        end
    endtask
`else
    task automatic test_gshare();
        logic [7:0] ghr_exp;
        logic       t;
        n_checks++;
        if (dut.ghr_q !== 8'h00) begin
            n_fail++;
            $display("FAIL ghr_after_init: got %h expected 00", dut.ghr_q);
        end
        do_upd(16'h0130, 1'b1, 16'h0300);
        n_checks++;
        if (dut.ghr_q !== 8'h01 || dut.pht_q[8'h30] !== 2'b10) begin
            n_fail++;
            $display("FAIL gs_first: got ghr=%h pht30=%b expected 01 10", dut.ghr_q, dut.pht_q[8'h30]);
        end
        do_upd(16'h0130, 1'b0, 16'h0300);
        n_checks++;
        if (dut.ghr_q !== 8'h02 || dut.pht_q[8'h31] !== 2'b00 || dut.pht_q[8'h30] !== 2'b10) begin
            n_fail++;
            $display("FAIL gs_distinct: got ghr=%h pht31=%b pht30=%b expected 02 00 10",
                     dut.ghr_q, dut.pht_q[8'h31], dut.pht_q[8'h30]);
        end
        ghr_exp = 8'h02;
        PC = 16'h0130;
        for (int k = 0; k < 16; k++) begin
            t = (k % 2 == 0);
            do_upd(16'h0130, t, 16'h0300);
            ghr_exp = {ghr_exp[6:0], t};
            n_checks++;
            if (dut.ghr_q !== ghr_exp) begin
                n_fail++;
                $display("FAIL gs_ghr step %0d: got %h expected %h", k, dut.ghr_q, ghr_exp);
            end
        end
        // History 0xAA -> next outcome taken; PHT[0x9A] saturated high.
        n_checks++;
        if (pred_taken !== 1'b1 || next_PC !== 16'h0300) begin
            n_fail++;
            $display("FAIL gs_pred_t: got pred=%b np=%h expected 1 0300", pred_taken, next_PC);
        end
        do_upd(16'h0130, 1'b1, 16'h0300);
        n_checks++;
        if (dut.ghr_q !== 8'h55 || pred_taken !== 1'b0 || next_PC !== 16'h0131) begin
            n_fail++;
            $display("FAIL gs_pred_nt: got ghr=%h pred=%b np=%h expected 55 0 0131",
                     dut.ghr_q, pred_taken, next_PC);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_restart();
        test_init_ignore_and_wrap();
`ifndef BTB_GSHARE_EN
        test_alloc_predict();
        test_counter();
        test_same_index();
`else
        test_gshare();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
